fifo_uart_tx: RTL
=================

# fifo_uart_tx

Serial transmitter that drains `fifo_sync` from its read side. It pops one word at a time through the FIFO's `rd`/`empty`/`data_out` handshake. Each word is serialised as an asynchronous frame: one start bit, DATA_WIDTH data bits sent LSB first, then STOP_BITS stop bits. The block sits between a `fifo_sync` instance and an off-chip serial line.

## Interface
- DATA_WIDTH, 8: word width; must match the FIFO's DATA_WIDTH.
- CLKS_PER_BIT, 16: clock cycles per serial bit; must be ≥ 2.
- STOP_BITS, 1: number of stop bits; legal values are 1 or 2.

- clk  input  1  single clock for the block.
- rst  input  1  asynchronous reset, active-high.
- enable  input  1  permits new FIFO pops; a frame already in progress always completes.
- fifo_empty  input  1  connects to the FIFO `empty` output.
- fifo_data  input  DATA_WIDTH  connects to the FIFO `data_out`; valid the cycle after an accepted `rd`.
- fifo_rd  output  1  connects to the FIFO `rd` input; one-cycle pop strobe.
- tx  output  1  serial line; idles high.
- busy  output  1  high from the fetch cycle through the last stop cycle.
- tx_done  output  1  one-cycle pulse after a frame's final stop cycle.

## Operation
- Reset values: state=IDLE, tx=1, busy=0, tx_done=0, fifo_rd=0, all counters 0.
- States: IDLE, FETCH, START, DATA, STOP.
- IDLE:
  - fifo_rd is combinational, equal to enable && !fifo_empty && !rst. It is only ever high in IDLE.
  - If fifo_rd=1, the next state is FETCH.
- FETCH: lasts 1 cycle; tx stays 1. At the closing edge:
  - shift register ← fifo_data;
  - tx ← 0;
  - baud counter ← 0;
  - next state START.
- START: lasts CLKS_PER_BIT cycles with tx=0. At the last cycle: tx ← shift[0], bit index ← 0, next state DATA.
- DATA: each bit is held for CLKS_PER_BIT cycles.
  - On each bit boundary the shift register shifts right and the bit index increments.
  - After bit DATA_WIDTH-1: tx ← 1, next state STOP.
- STOP: lasts STOP_BITS*CLKS_PER_BIT cycles with tx=1. Then next state IDLE, and tx_done ← 1 for exactly one cycle.
- busy is decoded from registered state: busy = (state != IDLE).
- Counter widths:
  - baud counter: $clog2(CLKS_PER_BIT) bits;
  - bit index: $clog2(DATA_WIDTH) bits;
  - stop counter: $clog2(2*CLKS_PER_BIT) bits.
  - No counter may wrap mid-phase.
- enable deasserted mid-frame: the frame finishes normally; no further pop occurs.
- fifo_empty rising while not in IDLE: ignored.
- A pop is issued only when the FIFO is non-empty, so data is never underrun.
- Reset asserted mid-operation:
  - tx goes to 1 asynchronously and the state goes to IDLE.
  - The word in flight is dropped. This includes a word already popped in FETCH.
  - No tx_done pulse is issued for the dropped word.

## Timing
- Pop strobe in cycle N. FETCH occupies N+1; tx falls at N+2.
- Frame length on the line: (1 + DATA_WIDTH + STOP_BITS) * CLKS_PER_BIT cycles.
- tx_done is high in the first IDLE cycle after the frame. A new pop may assert in that same cycle.
- Minimum idle-high gap between back-to-back frames is 2 clocks (the IDLE cycle plus the FETCH cycle) beyond the stop bits.
- fifo_rd is never high for two consecutive cycles.

## Structure
- Package `fifo_uart_pkg` holds:
  - the state enum (IDLE, FETCH, START, DATA, STOP);
  - the stop-count constant derived from STOP_BITS;
  - elaboration checks on CLKS_PER_BIT ≥ 2 and STOP_BITS ∈ {1,2}.
- One sub-module is natural: `bit_timer`. It is a CLKS_PER_BIT down-counter with load and a `tick` output at the bit boundary, and is reused for the START, DATA and STOP phases.
- Top-level wiring: `fifo_sync` read side connects straight to fifo_rd, fifo_empty and fifo_data. Its own reset is active-low, so the top level drives it with the inverse of rst.

## Test plan
All scenarios use CLKS_PER_BIT=4 and DATA_WIDTH=8 unless stated otherwise.
- **Reset.** Hold rst=1 with fifo_empty=0 and enable=1 → tx=1, fifo_rd=0, busy=0, tx_done=0 throughout.
- **Single word 0xA5**, popped at cycle N:
  - fifo_rd high only at N;
  - tx=0 for N+2..N+5;
  - data bits 1,0,1,0,0,1,0,1 at 4 cycles each over N+6..N+37;
  - tx=1 for N+38..N+41;
  - tx_done=1 at N+42 only.
- **Back-to-back 0x00 then 0xFF**, with the FIFO non-empty throughout:
  - second fifo_rd at N+42;
  - second start bit at N+44;
  - tx high for exactly N+38..N+43 between frames.
- **enable dropped at N+10** with 3 words queued → the first frame completes (tx_done at N+42) and no further fifo_rd occurs.
- **rst pulsed at N+20**, mid-DATA:
  - tx=1 and busy=0 in the same cycle;
  - no tx_done;
  - after release, the next queued word transmits with a full start bit.
- **STOP_BITS=2**, word 0x3C:
  - stop phase holds tx=1 for 8 cycles over N+38..N+45;
  - tx_done at N+46.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
// Shared types and elaboration helpers for the FIFO-fed UART transmitter.
// Pure declarations; no timing or flow control of its own.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    DATA,
    STOP
  } state_t;

  // Number of clock cycles the line is held high for the stop bits.
  function automatic int stop_len(input int stop_bits, input int clks_per_bit);
    return stop_bits * clks_per_bit;
  endfunction

  function automatic bit params_ok(input int clks_per_bit, input int stop_bits);
    return (clks_per_bit >= 2) && ((stop_bits == 1) || (stop_bits == 2));
  endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Read-side handshake between a fifo_sync instance and the transmitter.
// fifo_data is valid the cycle after fifo_rd; the pop waits while fifo_empty is high.
interface fifo_uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_rd;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;

  modport master (output fifo_rd, input fifo_empty, input fifo_data);
  modport slave  (input fifo_rd, output fifo_empty, output fifo_data);
endinterface

// File: rtl/fifo_uart_tx_bit_timer.sv
// Bit-period down-counter: tick marks the last cycle of every CLKS_PER_BIT window.
// load restarts a window one cycle ahead; it has no handshake and clears while en is low.
module bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic load,
  output logic tick
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] TOP = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (load || (cnt == '0)) begin
      cnt <= TOP;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = en && !load && (cnt == '0);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from a fifo_sync and sends start + LSB-first data + stop bits on tx.
// Pop to falling start edge is 2 cycles; no pop is issued while busy, disabled or empty.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  fifo_uart_tx_if.master fifo,
  output logic           tx,
  output logic           busy,
  output logic           tx_done
);
  localparam int BW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int SW       = $clog2(2 * CLKS_PER_BIT);
  localparam int STOP_LEN = stop_len(STOP_BITS, CLKS_PER_BIT);

  if (!params_ok(CLKS_PER_BIT, STOP_BITS)) begin : g_bad_params
    $error("fifo_uart_tx: CLKS_PER_BIT must be >= 2 and STOP_BITS must be 1 or 2");
  end

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] shift, shift_nxt, shr;
  logic [BW-1:0]         bit_idx, bit_idx_nxt;
  logic [SW-1:0]         stop_cnt, stop_cnt_nxt;
  logic                  tx_nxt, done_nxt, pop, tmr_load, tick;

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .en   (state != IDLE),
    .load (tmr_load),
    .tick (tick)
  );

  assign shr          = shift >> 1;
  assign fifo.fifo_rd = pop;
  assign busy         = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
      shift    <= '0;
      bit_idx  <= '0;
      stop_cnt <= '0;
    end else begin
      state    <= state_nxt;
      tx       <= tx_nxt;
      tx_done  <= done_nxt;
      shift    <= shift_nxt;
      bit_idx  <= bit_idx_nxt;
      stop_cnt <= stop_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    tx_nxt       = tx;
    done_nxt     = 1'b0;
    shift_nxt    = shift;
    bit_idx_nxt  = bit_idx;
    stop_cnt_nxt = stop_cnt;
    pop          = 1'b0;
    tmr_load     = 1'b0;
    case (state)
      IDLE: begin
        tx_nxt = 1'b1;
        if (enable && !fifo.fifo_empty && !rst) begin
          pop       = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        shift_nxt = fifo.fifo_data;
        tx_nxt    = 1'b0;
        tmr_load  = 1'b1;
        state_nxt = START;
      end
      START: begin
        if (tick) begin
          tx_nxt      = shift[0];
          bit_idx_nxt = '0;
          state_nxt   = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_idx == BW'(DATA_WIDTH - 1)) begin
            tx_nxt       = 1'b1;
            stop_cnt_nxt = '0;
            state_nxt    = STOP;
          end else begin
            shift_nxt   = shr;
            tx_nxt      = shr[0];
            bit_idx_nxt = bit_idx + 1'b1;
          end
        end
      end
      STOP: begin
        // Stop phase is timed per cycle so two stop bits need no extra bit-count state.
        if (stop_cnt == SW'(STOP_LEN - 1)) begin
          stop_cnt_nxt = '0;
          done_nxt     = 1'b1;
          state_nxt    = IDLE;
        end else begin
          stop_cnt_nxt = stop_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
